// File: rtl/baby_store_pkg.sv
// Shared constants and state encoding for the Manchester Baby main store.
package baby_store_pkg;

  localparam int unsigned WORDS          = 32;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned ADDR_W         = 5;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DUMP = 3'd3,
    HALT = 3'd4
  } state_t;

endpackage

// File: rtl/baby_store_ram.sv
// 32x32 store array: one clocked write port, two asynchronous read ports.
// The array is deliberately not reset so contents survive a store reset.
module baby_store_ram
  import baby_store_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] mem [WORDS];

  // Single write port, muxed between loader and core by the parent.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Zero-latency read ports for the core and the dump path.
  always_comb begin
    rdata_a = mem[raddr_a];
    rdata_b = mem[raddr_b];
  end

endmodule

// File: rtl/baby_store.sv
// Main store for the Baby core: byte-stream program loader that holds the
// core in reset, core RAM port while running, and byte readback on halt.
module baby_store
  import baby_store_pkg::*;
(
  input  logic              clock,
  input  logic              reset_i,
  input  logic              load_start_i,
  input  logic [7:0]        load_byte_i,
  input  logic              load_valid_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  output logic              cpu_reset_o,
  input  logic [ADDR_W-1:0] ram_addr_i,
  input  logic [DATA_W-1:0] ram_data_i,
  input  logic              ram_rw_en_i,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic              stop_lamp_i,
  output logic [7:0]        dump_byte_o,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [2:0]        state_o
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] word_addr_q, word_addr_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [23:0]       buf_q, buf_d;
  logic              load_done_q, load_done_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic [1:0]        dump_idx_q, dump_idx_d;

  logic              load_we;
  logic              core_we;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] dump_word;

  baby_store_ram u_ram (
    .clock   (clock),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (ram_addr_i),
    .rdata_a (ram_data_o),
    .raddr_b (dump_addr_q),
    .rdata_b (dump_word)
  );

  // State and counter registers.
  always_ff @(posedge clock or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      word_addr_q <= '0;
      byte_idx_q  <= '0;
      buf_q       <= '0;
      load_done_q <= 1'b0;
      dump_addr_q <= '0;
      dump_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      byte_idx_q  <= byte_idx_d;
      buf_q       <= buf_d;
      load_done_q <= load_done_d;
      dump_addr_q <= dump_addr_d;
      dump_idx_q  <= dump_idx_d;
    end
  end

  // Next-state, byte assembly and dump sequencing; load_start_i wins everywhere.
  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    byte_idx_d  = byte_idx_q;
    buf_d       = buf_q;
    load_done_d = load_done_q;
    dump_addr_d = dump_addr_q;
    dump_idx_d  = dump_idx_q;
    load_we     = 1'b0;

    if (load_start_i) begin
      state_d     = LOAD;
      word_addr_d = '0;
      byte_idx_d  = '0;
      load_done_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        LOAD: begin
          if (load_valid_i) begin
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              load_we     = 1'b1;
              word_addr_d = word_addr_q + 5'd1;
              if (word_addr_q == 5'(WORDS - 1)) begin
                state_d     = RUN;
                load_done_d = 1'b1;
              end
            end else begin
              buf_d[{byte_idx_q, 3'b000} +: 8] = load_byte_i;
            end
          end
        end
        RUN: begin
          if (stop_lamp_i) begin
            state_d     = DUMP;
            dump_addr_d = '0;
            dump_idx_d  = '0;
          end
        end
        DUMP: begin
          if (dump_ready_i) begin
            dump_idx_d = dump_idx_q + 2'd1;
            if (dump_idx_q == 2'd3) begin
              dump_addr_d = dump_addr_q + 5'd1;
              if (dump_addr_q == 5'(WORDS - 1)) begin
                state_d = HALT;
              end
            end
          end
        end
        HALT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Write-port mux: loader owns the port in LOAD, core only in RUN.
  always_comb begin
    core_we = (state_q == RUN) && ram_rw_en_i;
    we      = load_we || core_we;
    waddr   = load_we ? word_addr_q : ram_addr_i;
    wdata   = load_we ? {load_byte_i, buf_q} : ram_data_i;
  end

  // Moore-style handshake and status outputs.
  always_comb begin
    cpu_reset_o  = (state_q == IDLE) || (state_q == LOAD);
    load_ready_o = (state_q == LOAD);
    load_done_o  = load_done_q;
    dump_valid_o = (state_q == DUMP);
    dump_byte_o  = (state_q == DUMP) ? dump_word[{dump_idx_q, 3'b000} +: 8] : 8'h00;
    state_o      = state_q;
  end

endmodule
